line_memory_mp: RTL

//   Parametrised multi-port line-granular memory model; successor to the single-port physical

---
 rtl/mem_model_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/line_memory_mp.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_model_pkg.sv
// Shared types and width helpers for the multi-port line memory model.
package mem_model_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    localparam int MAX_PORTS = 8;
    localparam int LINE_W    = 128;

    typedef logic [LINE_W-1:0]            line_t;
    typedef logic [$clog2(MAX_PORTS)-1:0] port_idx_t;

    function automatic int offset_width(input int line_width);
        return $clog2(line_width / 8);
    endfunction

    function automatic int index_width(input int addr_width, input int line_width);
        return addr_width - offset_width(line_width);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping
// to the lowest requester below it when none is found.
module rr_arbiter
    import mem_model_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  port_idx_t            ptr_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output port_idx_t            idx_o,
    output logic                 valid_o
);

    port_idx_t idx_hi;
    port_idx_t idx_lo;
    logic      hit_hi;

    // Descending scan leaves the lowest matching index in each candidate.
    always_comb begin
        idx_hi = '0;
        idx_lo = '0;
        hit_hi = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_lo = port_idx_t'(i);
                if (port_idx_t'(i) >= ptr_i) begin
                    idx_hi = port_idx_t'(i);
                    hit_hi = 1'b1;
                end
            end
        end
        valid_o = |req_i;
        idx_o   = hit_hi ? idx_hi : idx_lo;
        grant_o = valid_o ? (NUM_PORTS'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/line_memory_mp.sv
// Multi-port line memory: one shared line array served round-robin with programmable latency.
// Define MEM_WMASK_EN to add the per-port byte write mask (wmask).
module line_memory_mp
    import mem_model_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int LATENCY    = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_PORTS-1:0]              read,
    input  logic [NUM_PORTS-1:0]              write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   address,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]   wdata,
`ifdef MEM_WMASK_EN
    input  logic [NUM_PORTS*LINE_WIDTH/8-1:0] wmask,
`endif
    output logic [NUM_PORTS-1:0]              resp,
    output logic [NUM_PORTS*LINE_WIDTH-1:0]   rdata
);

    localparam int OFF_W = offset_width(LINE_WIDTH);
    localparam int IDX_W = index_width(ADDR_WIDTH, LINE_WIDTH);
    localparam int BYTES = LINE_WIDTH / 8;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    port_idx_t                       ptr_q, ptr_d;
    logic [NUM_PORTS-1:0]            resp_q;
    logic [NUM_PORTS*LINE_WIDTH-1:0] rdata_q;

    port_idx_t                       port_q;
    logic [NUM_PORTS-1:0]            gnt_q;
    logic                            wr_q;
    logic [IDX_W-1:0]                idx_q;
    logic [LINE_WIDTH-1:0]           wdata_q;
    logic [BYTES-1:0]                wmask_q;
    logic [LINE_WIDTH-1:0]           mem_q [2**IDX_W];

    logic [NUM_PORTS-1:0]            arb_grant;
    port_idx_t                       arb_idx;
    logic                            arb_valid;
    logic                            grant_en;
    logic                            access_en;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .req_i   (read | write),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        grant_en  = 1'b0;
        access_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_en = 1'b1;
                    cnt_d    = CNT_LOAD;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    access_en = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                ptr_d   = (port_q == port_idx_t'(NUM_PORTS - 1)) ? '0 : port_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            resp_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            resp_q  <= access_en ? gnt_q : '0;
            if (access_en && !wr_q) begin
                rdata_q[port_q*LINE_WIDTH +: LINE_WIDTH] <= mem_q[idx_q];
            end
        end
    end

    // Request payload is captured once at grant; the port may drop its request afterwards.
    always_ff @(posedge clk) begin
        if (grant_en) begin
            port_q  <= arb_idx;
            gnt_q   <= arb_grant;
            wr_q    <= write[arb_idx];
            idx_q   <= address[arb_idx*ADDR_WIDTH + OFF_W +: IDX_W];
            wdata_q <= wdata[arb_idx*LINE_WIDTH +: LINE_WIDTH];
`ifdef MEM_WMASK_EN
            wmask_q <= wmask[arb_idx*BYTES +: BYTES];
`else
            wmask_q <= '1;
`endif
        end
    end

    // Storage is never cleared; the rst_n term stops a reset-aborted access from landing.
    always_ff @(posedge clk) begin
        if (rst_n && access_en && wr_q) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wmask_q[b]) begin
                    mem_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

    assign resp  = resp_q;
    assign rdata = rdata_q;

endmodule
